// File: rtl/cam_ctrl.sv
// Request front-end for a CAM: serialises lookup/insert requests into CAM
// READ/WRITE commands and tracks entry occupancy with round-robin eviction.
module cam_ctrl #(
  parameter int SIZE  = 8,
  parameter int WIDTH = 32,
  localparam int IW   = $clog2(SIZE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [WIDTH-1:0] req_key,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_hit,
  output logic [IW-1:0]    resp_idx,
  output logic             resp_evicted,
  output logic             cam_enable,
  output logic             cam_command,
  output logic [IW-1:0]    cam_write_idx,
  output logic [WIDTH-1:0] cam_data,
  input  logic             cam_hit,
  input  logic [IW-1:0]    cam_read_idx,
  output logic [IW:0]      count,
  output logic             full
);

  localparam logic [IW:0]   SIZE_C = (IW+1)'(SIZE);
  localparam logic [IW-1:0] LAST   = IW'(SIZE - 1);

  typedef enum logic [2:0] {IDLE, LOOK, CHECK, WRITE, RESP} state_t;

  state_t            state, next;
  logic              op;
  logic [WIDTH-1:0]  key;
  logic              hit;
  logic [IW-1:0]     idx;
  logic              evicted;
  logic [SIZE-1:0]   vld;
  logic [IW-1:0]     rr;
  logic [IW-1:0]     victim;
  logic              evict;

  // Lowest free slot wins; when every slot is occupied fall back to rr.
  always_comb begin
    victim = rr;
    evict  = 1'b1;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (!vld[i]) begin
        victim = IW'(i);
        evict  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (req_valid) next = LOOK;
      LOOK:    next = CHECK;
      CHECK:   next = (!op || cam_hit) ? RESP : WRITE;
      WRITE:   next = RESP;
      RESP:    if (resp_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op      <= 1'b0;
      key     <= '0;
      hit     <= 1'b0;
      idx     <= '0;
      evicted <= 1'b0;
      vld     <= '0;
      rr      <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op  <= req_op;
            key <= req_key;
          end
        end
        CHECK: begin
          // Lookups and duplicate inserts resolve here without touching the CAM.
          if (!op || cam_hit) begin
            hit     <= cam_hit;
            idx     <= cam_hit ? cam_read_idx : '0;
            evicted <= 1'b0;
          end
        end
        WRITE: begin
          vld[victim] <= 1'b1;
          hit         <= 1'b0;
          idx         <= victim;
          evicted     <= evict;
          if (evict) rr <= (rr == LAST) ? '0 : rr + 1'b1;
          else       count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = (state == IDLE);
  assign resp_valid    = (state == RESP);
  assign resp_hit      = hit;
  assign resp_idx      = idx;
  assign resp_evicted  = evicted;
  assign cam_enable    = (state == LOOK) || (state == WRITE);
  assign cam_command   = (state == WRITE);
  assign cam_write_idx = (state == WRITE) ? victim : '0;
  assign cam_data      = key;
  assign full          = (count == SIZE_C);

endmodule
